// File: rtl/minisys_pkg.sv
// minisys_pkg
//   Definitions shared by the MiniSys-1A fetch stage and the instruction
//   decoder: the nop encoding, the instruction field bit positions, the
//   default reset PC, the skid-buffer entry layout and a PC alignment helper.
package minisys_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field bit positions
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_MSB  = 5;
  localparam int FUNC_LSB  = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JIDX_MSB  = 25;
  localparam int JIDX_LSB  = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } skid_entry_t;

  // Word-align a byte address (drops the two low bits).
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if
//   Synchronous instruction-memory read bus.
//   imem_en     fetch -> memory  read enable
//   imem_addr   fetch -> memory  word address (IMEM_AW bits)
//   imem_rdata  memory -> fetch  read data, valid the cycle after imem_en
//   Modports: master = fetch unit, slave = instruction memory.
interface ifetch_unit_if #(
  parameter int IMEM_AW = 14
) ();

  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;

  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/ifetch_skid.sv
// ifetch_skid
//   One-entry {inst, pc} holding buffer that catches a returning imem word
//   while the consumer is stalled.
//   clk, rst              clock, synchronous active-high reset
//   flush                 empty the entry (highest priority)
//   load, load_inst/pc    capture a word (entry becomes valid)
//   drain                 consumer took the entry (entry becomes empty)
//   valid, inst, pc       current entry contents
module ifetch_skid
  import minisys_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        drain,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  skid_entry_t entry_reg;
  skid_entry_t entry_next;

  always_comb begin
    entry_next = entry_reg;
    if (flush) begin
      entry_next.valid = 1'b0;
    end else if (load) begin
      entry_next.valid = 1'b1;
      entry_next.inst  = load_inst;
      entry_next.pc    = load_pc;
    end else if (drain) begin
      entry_next.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_reg <= '0;
    end else begin
      entry_reg <= entry_next;
    end
  end

  assign valid = entry_reg.valid;
  assign inst  = entry_reg.inst;
  assign pc    = entry_reg.pc;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit
//   MiniSys-1A instruction fetch stage. Holds the PC, reads a synchronous
//   instruction memory (1-cycle latency) and presents the fetched word and its
//   decoded fields to the decoder. Stalls are absorbed by a one-entry skid
//   buffer; redirects squash the word in flight and restart fetch at the target.
//   clk, rst            clock, synchronous active-high reset
//   stall               consumer cannot accept; outputs hold
//   redirect/_pc        next fetch address (branch/jump/eret/exception)
//   imem                instruction memory bus (master side)
//   inst_valid          inst/inst_pc/fields carry a live instruction
//   inst, inst_pc       instruction word (nop when invalid) and its address
//   pc_plus4            inst_pc + 4, link value
//   op..jidx            field slices of inst
//   misalign_exc        one-cycle pulse when redirect_pc is not word aligned
module ifetch_unit
  import minisys_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  ifetch_unit_if.master imem,
  output logic          inst_valid,
  output logic [31:0]   inst,
  output logic [31:0]   inst_pc,
  output logic [31:0]   pc_plus4,
  output logic [5:0]    op,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [5:0]    func,
  output logic [15:0]   imm16,
  output logic [25:0]   jidx,
  output logic          misalign_exc
);

  typedef enum logic {
    RUN  = 1'b0,
    SKID = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_issue_reg, pc_issue_next;
  logic [31:0] resp_pc_reg, resp_pc_next;
  logic        resp_live_reg, resp_live_next;
  logic        inst_valid_reg, inst_valid_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] inst_pc_reg, inst_pc_next;
  logic [31:0] pc_plus4_reg, pc_plus4_next;
  logic        misalign_reg, misalign_next;

  logic        skid_load, skid_drain, skid_flush;
  logic        skid_valid;
  logic [31:0] skid_inst, skid_pc;

  ifetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (skid_flush),
    .load      (skid_load),
    .drain     (skid_drain),
    .load_inst (imem.imem_rdata),
    .load_pc   (resp_pc_reg),
    .valid     (skid_valid),
    .inst      (skid_inst),
    .pc        (skid_pc)
  );

  always_comb begin
    state_next      = state_reg;
    pc_issue_next   = pc_issue_reg;
    resp_pc_next    = resp_pc_reg;
    resp_live_next  = 1'b0;
    inst_valid_next = inst_valid_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    pc_plus4_next   = pc_plus4_reg;
    misalign_next   = 1'b0;
    skid_load       = 1'b0;
    skid_drain      = 1'b0;
    skid_flush      = 1'b0;

    if (redirect) begin
      // Redirect beats stall: drop the in-flight word and the skid, emit a bubble.
      pc_issue_next   = align_pc(redirect_pc);
      skid_flush      = 1'b1;
      inst_valid_next = 1'b0;
      inst_next       = NOP_INST;
      state_next      = RUN;
      misalign_next   = |redirect_pc[1:0];
    end else begin
      case (state_reg)
        RUN: begin
          if (stall && resp_live_reg) begin
            // Park the returning word. The read issued this cycle would have
            // nowhere to go next cycle, so it is discarded (resp_live stays 0)
            // and pc_issue is kept so that address is fetched again later.
            skid_load  = 1'b1;
            state_next = SKID;
          end else begin
            pc_issue_next  = pc_issue_reg + 32'd4;
            resp_live_next = 1'b1;
            resp_pc_next   = pc_issue_reg;
            if (!stall) begin
              if (resp_live_reg) begin
                inst_valid_next = 1'b1;
                inst_next       = imem.imem_rdata;
                inst_pc_next    = resp_pc_reg;
                pc_plus4_next   = resp_pc_reg + 32'd4;
              end else begin
                inst_valid_next = 1'b0;
                inst_next       = NOP_INST;
              end
            end
          end
        end
        SKID: begin
          if (!stall) begin
            inst_valid_next = skid_valid;
            inst_next       = skid_inst;
            inst_pc_next    = skid_pc;
            pc_plus4_next   = skid_pc + 32'd4;
            skid_drain      = 1'b1;
            state_next      = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RUN;
      pc_issue_reg   <= RESET_PC;
      resp_pc_reg    <= '0;
      resp_live_reg  <= 1'b0;
      inst_valid_reg <= 1'b0;
      inst_reg       <= NOP_INST;
      inst_pc_reg    <= '0;
      pc_plus4_reg   <= '0;
      misalign_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_issue_reg   <= pc_issue_next;
      resp_pc_reg    <= resp_pc_next;
      resp_live_reg  <= resp_live_next;
      inst_valid_reg <= inst_valid_next;
      inst_reg       <= inst_next;
      inst_pc_reg    <= inst_pc_next;
      pc_plus4_reg   <= pc_plus4_next;
      misalign_reg   <= misalign_next;
    end
  end

  // Reads stop while the skid holds a word and while reset is asserted.
  assign imem.imem_en   = (state_reg == RUN) && !rst;
  assign imem.imem_addr = pc_issue_reg[IMEM_AW+1:2];

  assign inst_valid   = inst_valid_reg;
  assign inst         = inst_reg;
  assign inst_pc      = inst_pc_reg;
  assign pc_plus4     = pc_plus4_reg;
  assign misalign_exc = misalign_reg;

  assign op    = inst_reg[OP_MSB:OP_LSB];
  assign rs    = inst_reg[RS_MSB:RS_LSB];
  assign rt    = inst_reg[RT_MSB:RT_LSB];
  assign rd    = inst_reg[RD_MSB:RD_LSB];
  assign shamt = inst_reg[SHAMT_MSB:SHAMT_LSB];
  assign func  = inst_reg[FUNC_MSB:FUNC_LSB];
  assign imm16 = inst_reg[IMM_MSB:IMM_LSB];
  assign jidx  = inst_reg[JIDX_MSB:JIDX_LSB];

endmodule
